// File: rtl/ahb2axi_bridge.sv
// AHB-Lite slave to AXI4 master bridge: each AHB beat becomes one single-beat
// AXI transaction, with the AHB data phase stretched until the AXI response.
module ahb2axi_bridge #(
    parameter int                      AXI_ID_WIDTH = 8,
    parameter logic [AXI_ID_WIDTH-1:0] AXI_ID       = '0
) (
    input  logic                    hclk,
    input  logic                    hreset,

    input  logic                    hsel,
    input  logic [31:0]             haddr,
    input  logic [1:0]              htrans,
    input  logic                    hwrite,
    input  logic [2:0]              hsize,
    input  logic [2:0]              hburst,
    input  logic [63:0]             hwdata,
    input  logic                    hready,
    output logic                    hreadyout,
    output logic                    hresp,
    output logic [63:0]             hrdata,

    output logic [AXI_ID_WIDTH-1:0] awid,
    output logic [31:0]             awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,

    output logic [63:0]             wdata,
    output logic [7:0]              wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,

    input  logic [AXI_ID_WIDTH-1:0] bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,

    output logic [AXI_ID_WIDTH-1:0] arid,
    output logic [31:0]             araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,

    input  logic [AXI_ID_WIDTH-1:0] rid,
    input  logic [63:0]             rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_WCAP = 4'd1;
    localparam logic [3:0] S_WAW  = 4'd2;
    localparam logic [3:0] S_WB   = 4'd3;
    localparam logic [3:0] S_RAR  = 4'd4;
    localparam logic [3:0] S_RR   = 4'd5;
    localparam logic [3:0] S_DONE = 4'd6;
    localparam logic [3:0] S_ERR1 = 4'd7;
    localparam logic [3:0] S_ERR2 = 4'd8;

    localparam logic [1:0] BURST_INCR = 2'b01;

    logic [3:0]  state;
    logic [3:0]  state_nxt;
    logic [31:0] addr_q;
    logic [2:0]  size_q;
    logic        accept_state;
    logic        accept;
    logic        aw_done;
    logic        w_done;
    logic        unused_inputs;

    // Burst type, IDs, rlast and the low response bits carry no meaning here.
    assign unused_inputs = ^{hburst, htrans[0], bid, bresp[0], rid, rresp[0], rlast};

    assign awid    = AXI_ID;
    assign arid    = AXI_ID;
    assign awlen   = '0;
    assign arlen   = '0;
    assign awburst = BURST_INCR;
    assign arburst = BURST_INCR;
    assign wlast   = 1'b1;
    assign awaddr  = addr_q;
    assign araddr  = addr_q;
    assign awsize  = size_q;
    assign arsize  = size_q;

    function automatic logic [7:0] strb_for(input logic [2:0] size, input logic [2:0] addr);
        logic [7:0] strb;
        case (size)
            3'd0:    strb = 8'h01 << addr;
            3'd1:    strb = 8'h03 << {addr[2:1], 1'b0};
            3'd2:    strb = 8'h0F << {addr[2], 2'b00};
            default: strb = 8'hFF;
        endcase
        return strb;
    endfunction

    assign accept_state = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR2);
    assign accept       = hsel && hready && htrans[1] && accept_state;

    // A channel counts as done once its valid has dropped or is handshaking now.
    assign aw_done = !awvalid || awready;
    assign w_done  = !wvalid  || wready;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR2: begin
                if (accept) begin
                    if (hsize[2])
                        state_nxt = S_ERR1;
                    else if (hwrite)
                        state_nxt = S_WCAP;
                    else
                        state_nxt = S_RAR;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_WCAP: state_nxt = S_WAW;
            S_WAW: begin
                if (aw_done && w_done)
                    state_nxt = S_WB;
            end
            S_WB: begin
                if (bvalid)
                    state_nxt = bresp[1] ? S_ERR1 : S_DONE;
            end
            S_RAR: begin
                if (arready)
                    state_nxt = S_RR;
            end
            S_RR: begin
                if (rvalid)
                    state_nxt = rresp[1] ? S_ERR1 : S_DONE;
            end
            S_ERR1:  state_nxt = S_ERR2;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state     <= S_IDLE;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
            hrdata    <= '0;
            addr_q    <= '0;
            size_q    <= '0;
            wdata     <= '0;
            wstrb     <= '0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
        end else begin
            state     <= state_nxt;
            hreadyout <= (state_nxt == S_IDLE) || (state_nxt == S_DONE) || (state_nxt == S_ERR2);
            hresp     <= (state_nxt == S_ERR1) || (state_nxt == S_ERR2);

            if (accept) begin
                addr_q <= haddr;
                size_q <= hsize;
                wstrb  <= strb_for(hsize, haddr[2:0]);
                if (!hsize[2] && !hwrite)
                    arvalid <= 1'b1;
            end

            case (state)
                S_WCAP: begin
                    wdata   <= hwdata;
                    awvalid <= 1'b1;
                    wvalid  <= 1'b1;
                end
                S_WAW: begin
                    if (awready)
                        awvalid <= 1'b0;
                    if (wready)
                        wvalid <= 1'b0;
                    if (aw_done && w_done)
                        bready <= 1'b1;
                end
                S_WB: begin
                    if (bvalid)
                        bready <= 1'b0;
                end
                S_RAR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                    end
                end
                S_RR: begin
                    // Read data is returned to AHB even when the response is an error.
                    if (rvalid) begin
                        rready <= 1'b0;
                        hrdata <= rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb2axi_bridge.sv
// Directed bench for ahb2axi_bridge with queue-based scoreboards for the AXI
// address/data channels and AHB read data.
module tb_ahb2axi_bridge;

    localparam int         IDW = 4;
    localparam logic [3:0] ID  = 4'h5;

    logic           hclk;
    logic           hreset;
    logic           hsel;
    logic [31:0]    haddr;
    logic [1:0]     htrans;
    logic           hwrite;
    logic [2:0]     hsize;
    logic [2:0]     hburst;
    logic [63:0]    hwdata;
    logic           hready;
    logic           hreadyout;
    logic           hresp;
    logic [63:0]    hrdata;
    logic [IDW-1:0] awid;
    logic [31:0]    awaddr;
    logic [7:0]     awlen;
    logic [2:0]     awsize;
    logic [1:0]     awburst;
    logic           awvalid;
    logic           awready;
    logic [63:0]    wdata;
    logic [7:0]     wstrb;
    logic           wlast;
    logic           wvalid;
    logic           wready;
    logic [IDW-1:0] bid;
    logic [1:0]     bresp;
    logic           bvalid;
    logic           bready;
    logic [IDW-1:0] arid;
    logic [31:0]    araddr;
    logic [7:0]     arlen;
    logic [2:0]     arsize;
    logic [1:0]     arburst;
    logic           arvalid;
    logic           arready;
    logic [IDW-1:0] rid;
    logic [63:0]    rdata;
    logic [1:0]     rresp;
    logic           rlast;
    logic           rvalid;
    logic           rready;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
    } ax_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
    } w_t;

    ax_t         aw_q[$];
    ax_t         ar_q[$];
    w_t          w_q[$];
    logic [63:0] rd_q[$];

    int checks;
    int failures;
    int aw_cycles;
    int w_cycles;
    int ar_cycles;

    // Single slave on the bus, so the bus-wide ready is this slave's ready.
    assign hready = hreadyout;

    ahb2axi_bridge #(
        .AXI_ID_WIDTH(IDW),
        .AXI_ID      (ID)
    ) dut (
        .hclk     (hclk),
        .hreset   (hreset),
        .hsel     (hsel),
        .haddr    (haddr),
        .htrans   (htrans),
        .hwrite   (hwrite),
        .hsize    (hsize),
        .hburst   (hburst),
        .hwdata   (hwdata),
        .hready   (hready),
        .hreadyout(hreadyout),
        .hresp    (hresp),
        .hrdata   (hrdata),
        .awid     (awid),
        .awaddr   (awaddr),
        .awlen    (awlen),
        .awsize   (awsize),
        .awburst  (awburst),
        .awvalid  (awvalid),
        .awready  (awready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wlast    (wlast),
        .wvalid   (wvalid),
        .wready   (wready),
        .bid      (bid),
        .bresp    (bresp),
        .bvalid   (bvalid),
        .bready   (bready),
        .arid     (arid),
        .araddr   (araddr),
        .arlen    (arlen),
        .arsize   (arsize),
        .arburst  (arburst),
        .arvalid  (arvalid),
        .arready  (arready),
        .rid      (rid),
        .rdata    (rdata),
        .rresp    (rresp),
        .rlast    (rlast),
        .rvalid   (rvalid),
        .rready   (rready)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (hreadyout !== 1'b1 && n < 20) begin
            n++;
            tick();
        end
    endtask

    task automatic ahb_addr(input logic wr, input logic [31:0] a, input logic [2:0] sz, input logic [1:0] tr);
        hsel   = 1'b1;
        htrans = tr;
        hwrite = wr;
        haddr  = a;
        hsize  = sz;
    endtask

    task automatic ahb_idle();
        hsel   = 1'b0;
        htrans = 2'b00;
    endtask

    // Channel monitor: handshakes are sampled mid-cycle, where they are stable.
    always @(negedge hclk) begin
        ax_t e;
        w_t  ew;
        if (!hreset) begin
            if (awvalid) aw_cycles++;
            if (wvalid)  w_cycles++;
            if (arvalid) ar_cycles++;
            if (awvalid && awready) begin
                check("aw_expected", 64'(aw_q.size() != 0), 64'd1);
                if (aw_q.size() != 0) begin
                    e = aw_q.pop_front();
                    check("awaddr", 64'(awaddr), 64'(e.addr));
                    check("awsize", 64'(awsize), 64'(e.size));
                    check("awlen", 64'(awlen), 64'd0);
                    check("awburst", 64'(awburst), 64'd1);
                    check("awid", 64'(awid), 64'(ID));
                end
            end
            if (wvalid && wready) begin
                check("w_expected", 64'(w_q.size() != 0), 64'd1);
                if (w_q.size() != 0) begin
                    ew = w_q.pop_front();
                    check("wdata", wdata, ew.data);
                    check("wstrb", 64'(wstrb), 64'(ew.strb));
                    check("wlast", 64'(wlast), 64'd1);
                end
            end
            if (arvalid && arready) begin
                check("ar_expected", 64'(ar_q.size() != 0), 64'd1);
                if (ar_q.size() != 0) begin
                    e = ar_q.pop_front();
                    check("araddr", 64'(araddr), 64'(e.addr));
                    check("arsize", 64'(arsize), 64'(e.size));
                    check("arlen", 64'(arlen), 64'd0);
                    check("arburst", 64'(arburst), 64'd1);
                    check("arid", 64'(arid), 64'(ID));
                end
            end
        end
    end

    initial begin
        int n;
        int base_aw;
        int base_w;
        int base_ar;
        logic [63:0] exp_rd;

        checks = 0;
        failures = 0;
        aw_cycles = 0;
        w_cycles = 0;
        ar_cycles = 0;
        hreset = 1'b1;
        hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = '0;
        hburst = 3'b001; hwdata = '0;
        awready = 1'b0; wready = 1'b0;
        bid = '0; bresp = 2'b00; bvalid = 1'b0;
        arready = 1'b0;
        rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;

        repeat (3) tick();
        check("rst_hreadyout", 64'(hreadyout), 64'd1);
        check("rst_hresp", 64'(hresp), 64'd0);
        check("rst_hrdata", hrdata, 64'd0);
        check("rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
        hreset = 1'b0;
        tick();

        // Word write with every AXI handshake immediate.
        ahb_addr(1'b1, 32'h1000_0004, 3'd2, 2'b10);
        aw_q.push_back('{addr: 32'h1000_0004, size: 3'd2});
        w_q.push_back('{data: 64'h1122334455667788, strb: 8'hF0});
        tick();
        ahb_idle();
        hwdata = 64'h1122334455667788;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
        wait_ready(n);
        check("wr1_wait_cycles", 64'(n), 64'd3);
        check("wr1_hresp", 64'(hresp), 64'd0);
        bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
        tick();

        // Doubleword read with arready delayed three cycles.
        base_ar = ar_cycles;
        ahb_addr(1'b0, 32'h2000_0000, 3'd3, 2'b10);
        ar_q.push_back('{addr: 32'h2000_0000, size: 3'd3});
        tick();
        ahb_idle();
        for (int i = 0; i < 3; i++) begin
            check("rd1_arvalid_wait", 64'({arvalid, hreadyout}), 64'b10);
            tick();
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check("rd1_arvalid_cycles", 64'(ar_cycles - base_ar), 64'd4);
        check("rd1_rready", 64'({arvalid, rready}), 64'b01);
        rvalid = 1'b1; rdata = 64'hDEADBEEF_CAFEF00D; rresp = 2'b00;
        rd_q.push_back(64'hDEADBEEF_CAFEF00D);
        tick();
        rvalid = 1'b0;
        check("rd1_done_ready", 64'({hreadyout, hresp}), 64'b10);
        exp_rd = rd_q.pop_front();
        check("rd1_hrdata", hrdata, exp_rd);
        tick();

        // wready two cycles ahead of awready, then SLVERR on B.
        ahb_addr(1'b1, 32'h3000_0016, 3'd1, 2'b10);
        aw_q.push_back('{addr: 32'h3000_0016, size: 3'd1});
        w_q.push_back('{data: 64'hCAFE_0000_BEEF_1111, strb: 8'hC0});
        tick();
        ahb_idle();
        hwdata = 64'hCAFE_0000_BEEF_1111;
        tick();
        check("wr2_both_valid", 64'({awvalid, wvalid}), 64'b11);
        wready = 1'b1;
        tick();
        wready = 1'b0;
        check("wr2_w_first", 64'({awvalid, wvalid, hreadyout}), 64'b100);
        tick();
        check("wr2_aw_held", 64'({awvalid, wvalid}), 64'b10);
        awready = 1'b1;
        tick();
        awready = 1'b0;
        check("wr2_in_wb", 64'({awvalid, bready, hreadyout}), 64'b010);
        bvalid = 1'b1; bresp = 2'b10;
        tick();
        bvalid = 1'b0; bresp = 2'b00;
        check("wr2_err1", 64'({hreadyout, hresp, bready}), 64'b010);
        tick();
        check("wr2_err2", 64'({hreadyout, hresp}), 64'b11);
        tick();
        check("wr2_after_err", 64'({hreadyout, hresp}), 64'b10);

        // Read followed by a SEQ byte write accepted in DONE.
        ahb_addr(1'b0, 32'h4000_0008, 3'd3, 2'b10);
        ar_q.push_back('{addr: 32'h4000_0008, size: 3'd3});
        rd_q.push_back(64'h0123456789ABCDEF);
        tick();
        ahb_idle();
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 64'h0123456789ABCDEF; rresp = 2'b00;
        ahb_addr(1'b1, 32'h4000_0013, 3'd0, 2'b11);
        aw_q.push_back('{addr: 32'h4000_0013, size: 3'd0});
        w_q.push_back('{data: 64'hA5A5_5A5A_0F0F_F0F0, strb: 8'h08});
        tick();
        rvalid = 1'b0;
        check("b2b_done", 64'({hreadyout, hresp}), 64'b10);
        exp_rd = rd_q.pop_front();
        check("b2b_hrdata", hrdata, exp_rd);
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
        tick();
        check("b2b_no_idle", 64'(hreadyout), 64'd0);
        ahb_idle();
        hwdata = 64'hA5A5_5A5A_0F0F_F0F0;
        wait_ready(n);
        check("b2b_wr_wait_cycles", 64'(n), 64'd3);
        check("b2b_wr_hresp", 64'(hresp), 64'd0);
        check("b2b_hrdata_held", hrdata, 64'h0123456789ABCDEF);
        bvalid = 1'b0;
        tick();

        // Illegal size: error response with no AXI activity even with ready high.
        base_aw = aw_cycles;
        base_w = w_cycles;
        ahb_addr(1'b1, 32'h7000_0000, 3'b100, 2'b10);
        tick();
        ahb_idle();
        check("bad_err1", 64'({hreadyout, hresp}), 64'b01);
        tick();
        check("bad_err2", 64'({hreadyout, hresp}), 64'b11);
        tick();
        check("bad_idle", 64'({hreadyout, hresp}), 64'b10);
        check("bad_no_aw", 64'(aw_cycles - base_aw), 64'd0);
        check("bad_no_w", 64'(w_cycles - base_w), 64'd0);

        // Reset while waiting on B, then a normal read.
        bvalid = 1'b0;
        ahb_addr(1'b1, 32'h5000_0000, 3'd3, 2'b10);
        aw_q.push_back('{addr: 32'h5000_0000, size: 3'd3});
        w_q.push_back('{data: 64'h0F0E0D0C0B0A0908, strb: 8'hFF});
        tick();
        ahb_idle();
        hwdata = 64'h0F0E0D0C0B0A0908;
        tick();
        tick();
        awready = 1'b0; wready = 1'b0;
        check("rst_in_wb", 64'({bready, hreadyout}), 64'b10);
        hreset = 1'b1;
        tick();
        hreset = 1'b0;
        check("rst_mid_ready", 64'({hreadyout, hresp, bready}), 64'b100);
        check("rst_mid_valids", 64'({awvalid, wvalid, arvalid, rready}), 64'd0);
        arready = 1'b1;
        ahb_addr(1'b0, 32'h6000_0000, 3'd2, 2'b10);
        ar_q.push_back('{addr: 32'h6000_0000, size: 3'd2});
        rd_q.push_back(64'h1122AABB3344CCDD);
        tick();
        ahb_idle();
        rvalid = 1'b1; rdata = 64'h1122AABB3344CCDD; rresp = 2'b00;
        wait_ready(n);
        rvalid = 1'b0; arready = 1'b0;
        check("post_rst_rd_wait", 64'(n), 64'd2);
        exp_rd = rd_q.pop_front();
        check("post_rst_hrdata", hrdata, exp_rd);
        check("post_rst_hresp", 64'(hresp), 64'd0);
        tick();

        check("aw_q_drained", 64'(aw_q.size()), 64'd0);
        check("w_q_drained", 64'(w_q.size()), 64'd0);
        check("ar_q_drained", 64'(ar_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb2axi_bridge.md
Name: ahb2axi_bridge

Overview:
- Single-clock AHB-Lite slave to AXI4 master bridge; the reverse direction of the team's AXI-to-AHB bridge.
- Lets an AHB master (CPU/DMA on the AHB fabric) reach AXI-side memory and peripherals.
- Every AHB beat becomes one single-beat AXI transaction. The AHB data phase is stretched with hreadyout until the AXI response returns.
- AXI SLVERR/DECERR responses are mapped to the two-cycle AHB ERROR response.

Parameters:
AXI_ID_WIDTH, 8, width of awid/arid/bid/rid
AXI_ID, 0, constant ID driven on awid/arid

Ports:
hclk  in  1  bridge clock (AHB and AXI sides)
hreset  in  1  synchronous active-high reset
hsel  in  1  slave select
haddr  in  32  AHB address
htrans  in  2  transfer type
hwrite  in  1  1=write
hsize  in  3  transfer size
hburst  in  3  burst type (ignored)
hwdata  in  64  write data
hready  in  1  bus-wide ready (previous transfer done)
hreadyout  out  1  slave ready
hresp  out  1  0=OKAY 1=ERROR
hrdata  out  64  read data
awid/awaddr/awlen/awsize/awburst  out  AXI_ID_WIDTH/32/8/3/2  write address
awvalid  out  1  write address valid
awready  in  1  write address ready
wdata/wstrb/wlast  out  64/8/1  write data
wvalid  out  1  write data valid
wready  in  1  write data ready
bid/bresp  in  AXI_ID_WIDTH/2  write response
bvalid  in  1  write response valid
bready  out  1  write response ready
arid/araddr/arlen/arsize/arburst  out  AXI_ID_WIDTH/32/8/3/2  read address
arvalid  out  1  read address valid
arready  in  1  read address ready
rid/rdata/rresp/rlast  in  AXI_ID_WIDTH/64/2/1  read response
rvalid  in  1  read response valid
rready  out  1  read data ready

Behaviour:

Reset and clocking:
- Single clock, hclk. Reset hreset is synchronous and active-high.
- Reset values: state=IDLE, hreadyout=1, hresp=0, hrdata=0, awvalid=wvalid=bready=arvalid=rready=0.
- Reset mid-transaction abandons the AXI transaction. hreset is applied to the AXI slave in the same cycle.

AHB accept:
- Accept states are IDLE, DONE and ERR2.
- A transfer is accepted when hsel & hready & htrans[1] in an accept state. The bridge latches haddr, hwrite and hsize.
- IDLE/BUSY transfers, or hsel=0, are not accepted: hreadyout=1, hresp=OKAY, no AXI activity.
- hburst is ignored; each SEQ beat is handled independently.

AXI constants and mapping:
- awlen=arlen=0, awburst=arburst=INCR(01), wlast=1, awid=arid=AXI_ID.
- awsize/arsize = latched hsize.
- awaddr/araddr = latched haddr, held stable while valid.
- wstrb is derived from latched hsize and haddr[2:0]:
  - size 0: 8'h01<<a[2:0]
  - size 1: 8'h03<<{a[2:1],1'b0}
  - size 2: 8'h0F<<{a[2],2'b00}
  - size 3: 8'hFF
- hsize>3 goes straight to ERR1 with no AXI access.

FSM (hreadyout=0 in every state except IDLE, DONE, ERR2):
- IDLE:
  - accepted write -> WCAP
  - accepted read -> RAR
- WCAP: capture hwdata into wdata -> WAW.
- WAW:
  - awvalid and wvalid are asserted together. Each is dropped independently on its own handshake; handshakes may be in the same or different cycles.
  - When both are complete -> WB.
- WB: bready=1. On bvalid: bresp[1]=0 -> DONE; else -> ERR1. bid is ignored.
- RAR: arvalid=1 until arready -> RR.
- RR:
  - rready=1. On rvalid, hrdata<=rdata; this is captured even on error.
  - rresp[1]=0 -> DONE; else -> ERR1.
  - rlast and rid are ignored.
- DONE: hreadyout=1, hresp=0. New accept -> WCAP/RAR; else -> IDLE.
- ERR1: hreadyout=0, hresp=1 -> ERR2.
- ERR2: hreadyout=1, hresp=1. New accept -> WCAP/RAR; else -> IDLE.

Timing and stability:
- Minimum latency with AXI ready/valid high immediately: write data phase = 4 cycles (WCAP, WAW, WB, DONE); read data phase = 3 cycles (RAR, RR, DONE).
- Back-to-back transfers are accepted in DONE with no idle cycle.
- hrdata holds its last read value until the next read completes.
- All AXI outputs are registered. valid never drops before its handshake.

Test Plan:
- Reset, then write haddr=0x1000_0004, hsize=2, hwdata=0x1122334455667788; awready/wready/bvalid immediate -> awaddr=0x10000004, awsize=2, wstrb=0xF0, wdata as given, awlen=0, wlast=1, hreadyout low for 3 cycles then high, hresp=0.
- Read at 0x2000_0000, size 3; arready delayed 3 cycles, then rdata=0xDEADBEEF_CAFEF00D, rresp=0 -> arvalid held 3+1 cycles, hrdata=0xDEADBEEFCAFEF00D in DONE, hresp=0.
- Write with wready before awready (2 cycles apart), then bresp=2'b10 -> wvalid drops first, awvalid later; AHB sees ERR1 (hreadyout=0, hresp=1) then ERR2 (hreadyout=1, hresp=1).
- Back-to-back NONSEQ read then SEQ write, second address phase presented during DONE -> second transfer starts with no IDLE cycle; byte write at haddr[2:0]=3 gives wstrb=0x08.
- hsize=3'b100 write -> ERR1/ERR2 response, awvalid/wvalid never asserted.
- hreset asserted while in WB with bvalid low -> next cycle hreadyout=1, bready=0, state IDLE; next transfer completes normally.
